// File: rtl/mac_feeder.sv
// mac_feeder: operand sequencer and result checker for the MAC datapath.
//
// A host preloads an N-entry input buffer and an N-entry weight buffer while
// the block is idle. A start pulse streams the N operand pairs to the MAC
// with both data strobes high, waits LAT cycles, captures mac_out and
// compares it with a signed dot product accumulated internally.
//
// Handshake: there is no back-pressure. Writes and start are only honoured
// while idle (busy=0); the strobes mark exactly the N cycles in which
// feed_in/feed_w carry valid operands; result_valid is a single-cycle pulse
// during which result, expected and mismatch are all valid.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data   buffer write port (sel 0=input, 1=weight)
//   start                   begin a run (idle only)
//   feed_in, feed_w         operands to the MAC
//   strobe_in, strobe_w     operand strobes
//   mac_out                 result returned by the MAC
//   result, expected        captured MAC result and internal dot product
//   result_valid            one-cycle pulse, result/expected valid
//   mismatch                result != expected, held until the next run
//   busy                    run in progress
module mac_feeder #(
   parameter int DW  = 4,
   parameter int N   = 4,
   parameter int AW  = 2,
   parameter int LAT = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic [DW-1:0]   feed_in,
   output logic [DW-1:0]   feed_w,
   output logic            strobe_in,
   output logic            strobe_w,
   input  logic [2*DW-1:0] mac_out,
   output logic [2*DW-1:0] result,
   output logic [2*DW-1:0] expected,
   output logic            result_valid,
   output logic            mismatch,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [AW:0]   N_W      = (AW+1)'(N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N-1);
   localparam logic [CW-1:0] LAST_WT  = CW'(LAT-1);

   state_t          state_q;
   logic [AW-1:0]   idx_q;       // index currently on feed_in/feed_w
   logic [CW-1:0]   wait_q;
   logic [DW-1:0]   inbuf_q [N];
   logic [DW-1:0]   wbuf_q  [N];
   logic [DW-1:0]   inbuf_d [N];
   logic [DW-1:0]   wbuf_d  [N];
   logic [DW-1:0]   feed_in_q;
   logic [DW-1:0]   feed_w_q;
   logic            strobe_q;
   logic [2*DW-1:0] result_q;
   logic [2*DW-1:0] expected_q;
   logic            result_valid_q;
   logic            mismatch_q;
   logic            busy_q;
   logic [2*DW-1:0] prod;

   // Post-write view of the buffers. Loading the first operand pair from the
   // _d view lets a write in the same cycle as start reach the run.
   always_comb begin
      inbuf_d = inbuf_q;
      wbuf_d  = wbuf_q;
      if (state_q == S_IDLE && wr_en && ({1'b0, wr_addr} < N_W)) begin
         if (wr_sel) wbuf_d[wr_addr]  = wr_data;
         else        inbuf_d[wr_addr] = wr_data;
      end
   end

   // Sign-extend both operands to 2*DW so the truncated product is the
   // correct signed product modulo 2^(2*DW).
   assign prod = {{DW{feed_in_q[DW-1]}}, feed_in_q} *
                 {{DW{feed_w_q[DW-1]}},  feed_w_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         wait_q         <= '0;
         for (int i = 0; i < N; i++) begin
            inbuf_q[i] <= '0;
            wbuf_q[i]  <= '0;
         end
         feed_in_q      <= '0;
         feed_w_q       <= '0;
         strobe_q       <= 1'b0;
         result_q       <= '0;
         expected_q     <= '0;
         result_valid_q <= 1'b0;
         mismatch_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         inbuf_q <= inbuf_d;
         wbuf_q  <= wbuf_d;
         case (state_q)
            S_IDLE: begin
               result_valid_q <= 1'b0;
               if (start) begin
                  state_q    <= S_ISSUE;
                  idx_q      <= '0;
                  expected_q <= '0;
                  mismatch_q <= 1'b0;
                  busy_q     <= 1'b1;
                  strobe_q   <= 1'b1;
                  feed_in_q  <= inbuf_d[0];
                  feed_w_q   <= wbuf_d[0];
               end
            end
            S_ISSUE: begin
               // Accumulate the pair shown during the cycle just ending.
               expected_q <= expected_q + prod;
               if (idx_q == LAST_IDX) begin
                  state_q   <= S_WAIT;
                  wait_q    <= '0;
                  strobe_q  <= 1'b0;
                  feed_in_q <= '0;
                  feed_w_q  <= '0;
               end else begin
                  idx_q     <= idx_q + AW'(1);
                  feed_in_q <= inbuf_q[idx_q + AW'(1)];
                  feed_w_q  <= wbuf_q[idx_q + AW'(1)];
               end
            end
            S_WAIT: begin
               if (wait_q == LAST_WT) begin
                  state_q        <= S_REPORT;
                  result_q       <= mac_out;
                  mismatch_q     <= (mac_out != expected_q);
                  result_valid_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_REPORT: begin
               state_q        <= S_IDLE;
               result_valid_q <= 1'b0;
               busy_q         <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign feed_in      = feed_in_q;
   assign feed_w       = feed_w_q;
   assign strobe_in    = strobe_q;
   assign strobe_w     = strobe_q;
   assign result       = result_q;
   assign expected     = expected_q;
   assign result_valid = result_valid_q;
   assign mismatch     = mismatch_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: a run-position model predicts every output each
// cycle, and directed scenarios pin hand-computed results.
module tb_mac_feeder;

   localparam int DW  = 4;
   localparam int N   = 4;
   localparam int AW  = 2;
   localparam int LAT = 3;
   localparam int RUN = N + LAT + 1;   // run position of the REPORT cycle

   logic            clk;
   logic            reset;
   logic            wr_en;
   logic            wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            start;
   logic [DW-1:0]   feed_in;
   logic [DW-1:0]   feed_w;
   logic            strobe_in;
   logic            strobe_w;
   logic [2*DW-1:0] mac_out;
   logic [2*DW-1:0] result;
   logic [2*DW-1:0] expected;
   logic            result_valid;
   logic            mismatch;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 0;

   mac_feeder #(.DW(DW), .N(N), .AW(AW), .LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start),
      .feed_in(feed_in), .feed_w(feed_w),
      .strobe_in(strobe_in), .strobe_w(strobe_w),
      .mac_out(mac_out),
      .result(result), .expected(expected),
      .result_valid(result_valid), .mismatch(mismatch), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // k = cycles since the accepted start edge (0 = idle).
   int          k = 0;
   logic [DW-1:0]   m_in [N];
   logic [DW-1:0]   m_w  [N];
   logic [2*DW-1:0] m_dot = '0;
   logic [2*DW-1:0] m_res = '0;
   logic [2*DW-1:0] m_exp = '0;
   logic            m_mis = 1'b0;

   function automatic logic [2*DW-1:0] dot_fn();
      int s;
      s = 0;
      for (int i = 0; i < N; i++)
         s += int'($signed(m_in[i])) * int'($signed(m_w[i]));
      return (2*DW)'(s);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         k = 0;
         for (int i = 0; i < N; i++) begin
            m_in[i] = '0;
            m_w[i]  = '0;
         end
         m_res = '0; m_exp = '0; m_mis = 1'b0;
      end else if (k == 0) begin
         if (wr_en) begin
            if (wr_sel) m_w[wr_addr]  = wr_data;
            else        m_in[wr_addr] = wr_data;
         end
         if (start) begin
            k = 1; m_exp = '0; m_mis = 1'b0; m_dot = dot_fn();
         end
      end else if (k == N + LAT) begin
         m_res = mac_out; m_exp = m_dot; m_mis = (mac_out != m_dot); k = k + 1;
      end else if (k == RUN) begin
         k = 0;
      end else begin
         k = k + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic          strb;
         logic [DW-1:0] ei, ew;
         strb = (k >= 1 && k <= N);
         ei = strb ? m_in[k-1] : '0;
         ew = strb ? m_w[k-1]  : '0;
         chk("busy", busy, (k >= 1 && k <= RUN));
         chk("strobe_in", strobe_in, strb);
         chk("strobe_w", strobe_w, strb);
         chk("feed_in", feed_in, ei);
         chk("feed_w", feed_w, ew);
         chk("result_valid", result_valid, (k == RUN));
         chk("result", result, m_res);
         chk("mismatch", mismatch, m_mis);
         if (k == 0 || k == RUN) chk("expected", expected, m_exp);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_buf(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load(input logic sel, input logic [DW-1:0] v0, v1, v2, v3);
      write_buf(sel, 2'd0, v0);
      write_buf(sel, 2'd1, v1);
      write_buf(sel, 2'd2, v2);
      write_buf(sel, 2'd3, v3);
   endtask

   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for the REPORT cycle, checks literal values, then steps to idle.
   task automatic wait_result(input string name, input logic [7:0] r, e, input logic m);
      int n;
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (result_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_result_valid required=result_valid", name);
      end else begin
         chk({name, "_result"}, result, r);
         chk({name, "_expected"}, expected, e);
         chk({name, "_mismatch"}, mismatch, m);
      end
      @(negedge clk);
   endtask

   task automatic count_valid(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (result_valid === 1'b1) cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nv;
      int tv [3];
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; mac_out = '0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_result", result, 8'h00);
      reset = 1'b0;
      @(negedge clk);

      // Basic run: 1+2+3+4 = 10
      load(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
      load(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
      mac_out = 8'h0A;
      start_run();
      wait_result("basic", 8'h0A, 8'h0A, 1'b0);

      // Signed wrap: 4 * (-8 * -8) = 256 -> 0x00
      load(1'b0, 4'h8, 4'h8, 4'h8, 4'h8);
      load(1'b1, 4'h8, 4'h8, 4'h8, 4'h8);
      mac_out = 8'h00;
      start_run();
      wait_result("wrap", 8'h00, 8'h00, 1'b0);

      // Mixed signs: 7*-8 + -1*3 + 0*5 + 2*-1 = -61 -> 0xC3
      load(1'b0, 4'd7, 4'hF, 4'd0, 4'd2);
      load(1'b1, 4'h8, 4'd3, 4'd5, 4'hF);
      mac_out = 8'hC3;
      start_run();
      wait_result("signed", 8'hC3, 8'hC3, 1'b0);

      // Mismatch: MAC returns 0x0B instead of 0x0A
      load(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
      load(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
      mac_out = 8'h0B;
      start_run();
      wait_result("mis", 8'h0B, 8'h0A, 1'b1);
      repeat (4) @(negedge clk);
      chk("mis_held", mismatch, 1'b1);

      // Busy protection: write and start during ISSUE are ignored
      mac_out = 8'h0A;
      start_run();
      chk("mis_cleared", mismatch, 1'b0);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 4'd5; start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      wait_result("busy", 8'h0A, 8'h0A, 1'b0);
      count_valid(12, nv);
      chk("busy_single_valid", nv, 0);
      start_run();
      wait_result("persist", 8'h0A, 8'h0A, 1'b0);

      // Reset in the 2nd ISSUE cycle
      start_run();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_strobe", strobe_in, 1'b0);
      chk("rst_busy", busy, 1'b0);
      count_valid(12, nv);
      chk("rst_no_valid", nv, 0);
      mac_out = 8'h00;
      start_run();
      wait_result("after_rst", 8'h00, 8'h00, 1'b0);

      // Back-to-back with start held high
      load(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
      load(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
      mac_out = 8'h0A;
      start = 1'b1;
      nv = 0;
      for (int n = 0; n < 40 && nv < 3; n++) begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            chk("b2b_expected", expected, 8'h0A);
            tv[nv] = cyc;
            nv++;
         end
      end
      start = 1'b0;
      chk("b2b_count", nv, 3);
      if (nv == 3) begin
         chk("b2b_period0", tv[1] - tv[0], N + LAT + 2);
         chk("b2b_period1", tv[2] - tv[1], N + LAT + 2);
      end
      repeat (3) @(negedge clk);

      // Write together with start: write lands first (1+2+3+6 = 12)
      mac_out = 8'h0C;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd3; wr_data = 4'd6; start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      chk("same_cycle_feed", feed_in, 4'd1);
      wait_result("same_cycle", 8'h0C, 8'h0C, 1'b0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
Drives the operand side of the MAC datapath and collects its result.
- A host preloads an N-entry input buffer and an N-entry weight buffer.
- On start, the block streams N operand pairs with both data strobes asserted, waits a fixed latency, then captures the MAC result.
- It also computes a golden signed dot product internally and flags any mismatch. Used for datapath bring-up and as the sequencer ahead of the MAC array.

Parameters:
DW, 4, operand width (signed two's complement); result width is 2*DW
N, 4, operand pairs per run (vector length)
AW, 2, buffer address width; N <= 2**AW
LAT, 3, cycles from last strobe cycle to mac_out sample point

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high
wr_en  input  1  buffer write enable
wr_sel  input  1  0 = input buffer, 1 = weight buffer
wr_addr  input  AW  buffer entry index
wr_data  input  DW  value written
start  input  1  begin a run (sampled in IDLE only)
feed_in  output  DW  operand to MAC input port
feed_w  output  DW  weight to MAC weight port
strobe_in  output  1  data strobe for feed_in
strobe_w  output  1  data strobe for feed_w
mac_out  input  2*DW  result returned by MAC
result  output  2*DW  captured mac_out
expected  output  2*DW  internally computed dot product
result_valid  output  1  one-cycle pulse, result/expected valid
mismatch  output  1  result != expected, valid with result_valid, held until next run
busy  output  1  run in progress

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE; both buffers cleared to 0; feed_in, feed_w, strobe_in, strobe_w, result, expected, result_valid, mismatch, busy all 0. Reset mid-run aborts immediately: strobes are 0 the cycle after the reset edge, and no result_valid is produced.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, REPORT.
- IDLE:
  - wr_en writes wr_data to the buffer selected by wr_sel at wr_addr. Addresses >= N are ignored.
  - start=1 at posedge t: clear expected to 0, clear mismatch, set index to 0, go to ISSUE.
  - If wr_en and start occur in the same cycle, the write lands first and is used by the run.
- ISSUE: cycles t+1 .. t+N.
  - Index i = 0..N-1 drives feed_in=inbuf[i], feed_w=wbuf[i], strobe_in=strobe_w=1.
  - Strobes stay high for exactly N consecutive cycles.
  - expected accumulates sign-extended inbuf[i]*wbuf[i], wrapping modulo 2^(2*DW).
  - After i=N-1, go to WAIT.
- WAIT: cycles t+N+1 .. t+N+LAT.
  - Strobes are 0; feed_in and feed_w are 0.
  - A counter runs LAT cycles. mac_out is sampled into result at the posedge ending the last WAIT cycle.
- REPORT: cycle t+N+LAT+1.
  - result_valid=1 and mismatch=(result != expected).
  - Next state is IDLE.
- busy is 1 from t+1 through t+N+LAT+1 inclusive. A start asserted in the cycle after REPORT (IDLE) is accepted.
- wr_en while busy: ignored, buffers unchanged. start while busy: ignored, no queuing.
- Buffers persist across runs; a rerun without writes repeats the same operands.
- result and expected hold until the next capture.
- Arithmetic: each product is a DW×DW signed multiply giving 2*DW bits; the sum wraps (no saturation).

Test Plan:
- Basic: inbuf=1,2,3,4 and wbuf=1,1,1,1, start; MAC model returns 0x0A → strobes high 4 cycles from t+1, result_valid at t+8, result=expected=0x0A, mismatch=0, busy low at t+9.
- Signed/wrap: inbuf=all 0x8 (-8), wbuf=all 0x8 → expected=256 mod 256=0x00. Second run with inbuf=7,-1,0,2 and wbuf=-8,3,5,-1 → expected=-61=0xC3.
- Mismatch: repeat the basic run with the bench driving mac_out=0x0B at the sample point → result=0x0B, expected=0x0A, mismatch=1; mismatch stays 1 until the next start clears it.
- Busy protection: during ISSUE, pulse wr_en (addr0=5) and start → run result unchanged (0x0A), only one result_valid; afterwards inbuf[0] is still 1.
- Reset mid-run: assert reset in the 2nd ISSUE cycle → next cycle strobes=0, busy=0, no result_valid; a following run with no writes gives expected=0x00.
- Back-to-back: start held high continuously → new ISSUE begins the cycle after REPORT, strobes repeat every N+LAT+2 cycles, each run gives result_valid with a correct expected.
